// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter: size codes, FSM states,
// requester identifiers and the default MOC timeout.
package mem_arb_pkg;

    // MS_2_0 size codes understood by ram256x8
    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    // Cycles allowed in STROBE without MOC before the access is aborted
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETUP   = 2'b01,
        ST_STROBE  = 2'b10,
        ST_RELEASE = 2'b11
    } arb_state_t;

    typedef enum logic {
        SRC_FETCH = 1'b0,
        SRC_DATA  = 1'b1
    } arb_src_t;

    // The RAM has no encoding with both low size bits set
    function automatic logic size_is_legal(input logic [2:0] size);
        return size[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker. On a tie the requester that was not served
// last wins; a lone request always wins. The last-served flag resets to
// input b so input a takes the first tie.
module mem_arb_rr (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b;

    assign gnt_a = req_a && (!req_b || last_b);
    assign gnt_b = req_b && (!req_a || !last_b);

    // Remember who was served when the grant is actually taken
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // pre-edge values, independent of the order the blocks are evaluated.
        if (reset) begin
            last_b <= 1'b1;
        end else if (take && (gnt_a || gnt_b)) begin
            last_b <= gnt_b;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single MOV/MOC port of ram256x8 between instruction fetch and
// load/store. Each access runs IDLE -> SETUP -> STROBE -> RELEASE: fields are
// presented with MOV low for a cycle, MOV is held until MOC (or timeout),
// then MOV drops and the port waits for MOC to fall before going idle again.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [2:0]  MS_2_0,
    output logic [31:0] DataIn,
    output logic [31:0] Address,
    input  logic        MOC,
    input  logic [31:0] DataOut
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    arb_state_t       state;
    arb_state_t       state_next;
    arb_src_t         src;
    logic [CNT_W-1:0] strobe_cnt;
    logic             gnt_fetch;
    logic             gnt_data;
    logic             grant;
    logic             size_ok;
    logic             strobe_end;

    mem_arb_rr u_rr (
        .clk   (CLK),
        .reset (RESET),
        .req_a (if_req),
        .req_b (d_req),
        .take  (grant),
        .gnt_a (gnt_fetch),
        .gnt_b (gnt_data)
    );

    assign size_ok    = size_is_legal(d_size);
    // MOC has priority: a response in the last allowed cycle still succeeds
    assign strobe_end = MOC || (strobe_cnt == CNT_LAST);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an illegal data size skips the RAM entirely
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_next = state;
        grant      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    grant      = 1'b1;
                    state_next = (gnt_data && !size_ok) ? ST_RELEASE : ST_SETUP;
                end
            end
            ST_SETUP:   state_next = ST_STROBE;
            ST_STROBE:  if (strobe_end) state_next = ST_RELEASE;
            ST_RELEASE: if (!MOC) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // RAM-facing fields, strobe counter, acks and read-data capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            src        <= SRC_DATA;
            strobe_cnt <= '0;
            MOV        <= 1'b0;
            ReadWrite  <= 1'b1;
            MS_2_0     <= 3'b000;
            Address    <= '0;
            DataIn     <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            // acks and err are single-cycle pulses
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        if (gnt_fetch) begin
                            src       <= SRC_FETCH;
                            ReadWrite <= 1'b1;
                            MS_2_0    <= SIZE_WORD;
                            Address   <= if_addr;
                        end else if (size_ok) begin
                            src       <= SRC_DATA;
                            ReadWrite <= d_rw;
                            MS_2_0    <= d_size;
                            Address   <= d_addr;
                            DataIn    <= d_wdata;
                        end else begin
                            src   <= SRC_DATA;
                            d_ack <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    MOV        <= 1'b1;
                    strobe_cnt <= '0;
                end
                ST_STROBE: begin
                    if (strobe_end) begin
                        MOV <= 1'b0;
                        err <= !MOC;
                        if (src == SRC_FETCH) begin
                            if_ack <= 1'b1;
                        end else begin
                            d_ack <= 1'b1;
                        end
                        // A timed-out read returns zero rather than stale data
                        if (ReadWrite) begin
                            if (src == SRC_FETCH) begin
                                if_rdata <= MOC ? DataOut : '0;
                            end else begin
                                d_rdata <= MOC ? DataOut : '0;
                            end
                        end
                    end else begin
                        strobe_cnt <= strobe_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a byte-array RAM with configurable MOC delay and
// MOC hold, a transaction-schedule reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int TIMEOUT    = 15;
    localparam int ACK_BUDGET = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_rw, d_ack, err;
    logic [2:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mov, read_write, moc;
    logic [2:0]  ms;
    logic [31:0] data_in, address, data_out;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .RESET(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .MOV(mov), .ReadWrite(read_write), .MS_2_0(ms), .DataIn(data_in),
        .Address(address), .MOC(moc), .DataOut(data_out)
    );

    // ---------------- RAM environment (big-endian byte array) ----------------
    logic [7:0] mem [256];
    int         ram_delay;   // MOC rises in this STROBE cycle (0 = combinational)
    int         ram_hold;    // extra cycles MOC stays high after MOV falls
    int         scnt = 0;
    int         hcnt = 0;
    logic       bk_we;
    logic [7:0] bk_addr, bk_data;
    logic [7:0] ra0, ra1, ra2, ra3;

    assign moc = mov ? (scnt >= ram_delay) : (hcnt > 0);

    always_comb begin
        ra0 = address[7:0];
        ra1 = ra0 + 8'd1;
        ra2 = ra0 + 8'd2;
        ra3 = ra0 + 8'd3;
        case (ms[1:0])
            2'b00:   data_out = {24'h0, mem[ra0]};
            2'b01:   data_out = {16'h0, mem[ra0], mem[ra1]};
            default: data_out = {mem[ra0], mem[ra1], mem[ra2], mem[ra3]};
        endcase
    end

    always @(posedge clk) begin
        if (bk_we) mem[bk_addr] <= bk_data;
        if (mov) begin
            if (scnt >= ram_delay) begin
                if (!read_write) begin
                    case (ms[1:0])
                        2'b00: mem[ra0] <= data_in[7:0];
                        2'b01: begin
                            mem[ra0] <= data_in[15:8];
                            mem[ra1] <= data_in[7:0];
                        end
                        default: begin
                            mem[ra0] <= data_in[31:24];
                            mem[ra1] <= data_in[23:16];
                            mem[ra2] <= data_in[15:8];
                            mem[ra3] <= data_in[7:0];
                        end
                    endcase
                end
                hcnt <= ram_hold;
            end else begin
                scnt <= scnt + 1;
            end
        end else begin
            scnt <= 0;
            if (hcnt > 0) hcnt <= hcnt - 1;
        end
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] s);
        logic [7:0] p;
        p = a[7:0];
        case (s[1:0])
            2'b00:   return {24'h0, mem[p]};
            2'b01:   return {16'h0, mem[p], mem[p + 8'd1]};
            default: return {mem[p], mem[p + 8'd1], mem[p + 8'd2], mem[p + 8'd3]};
        endcase
    endfunction

    function automatic logic [7:0] preload(input int i);
        case (i)
            5: return 8'h12;   6: return 8'h34;   7: return 8'h56;   8: return 8'h78;
            14: return 8'h5A;
            18: return 8'hDE; 19: return 8'hAD; 20: return 8'hBE; 21: return 8'hEF;
            default: return 8'((i * 29 + 7) & 255);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction schedule) ----------------
    // A granted access occupies cycles t = 0.. after the grant edge:
    // legal: t=0 set-up, t=1..L strobe, t=L+1 ack, then `rel` release cycles;
    // illegal size: a single ack cycle at t=0.
    bit          m_valid = 0;
    bit          m_active = 0;
    bit          m_last_data = 1;
    bit          m_is_data, m_illegal, m_err, m_rw;
    int          m_t, m_len, m_rel, m_total;
    logic [2:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [31:0] e_if_rdata = '0;
    logic [31:0] e_d_rdata  = '0;

    task automatic compare_cycle();
        bit e_mov, e_ack;
        e_mov = m_active && !m_illegal && m_t >= 1 && m_t <= m_len;
        e_ack = m_active && (m_illegal ? (m_t == 0) : (m_t == m_len + 1));
        check("mov", 32'(mov), 32'(e_mov));
        check("if_ack", 32'(if_ack), 32'(e_ack && !m_is_data));
        check("d_ack", 32'(d_ack), 32'(e_ack && m_is_data));
        check("err", 32'(err), 32'(e_ack && m_err));
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        if (e_mov) begin
            check("address", address, m_addr);
            check("read_write", 32'(read_write), 32'(m_rw));
            check("ms", 32'(ms), 32'(m_size));
            if (!m_rw) check("data_in", data_in, m_wdata);
        end
    endtask

    task automatic model_step();
        bit slow;
        if (reset) begin
            m_active    = 0;
            m_last_data = 1;
            e_if_rdata  = '0;
            e_d_rdata   = '0;
            m_valid     = 1;
            return;
        end
        if (!m_valid) return;
        if (m_active) begin
            m_t++;
            if (m_t >= m_total) m_active = 0;
        end else if (if_req || d_req) begin
            m_is_data   = d_req && (!if_req || !m_last_data);
            m_last_data = m_is_data;
            m_active    = 1;
            m_t         = 0;
            if (m_is_data) begin
                m_rw = d_rw; m_size = d_size; m_addr = d_addr; m_wdata = d_wdata;
            end else begin
                m_rw = 1'b1; m_size = SIZE_WORD; m_addr = if_addr; m_wdata = '0;
            end
            slow      = ram_delay > TIMEOUT;
            m_illegal = m_is_data && (d_size[1:0] == 2'b11);
            m_err     = m_illegal || slow;
            m_len     = slow ? TIMEOUT + 1 : ram_delay + 1;
            m_rel     = m_err ? 1 : ram_hold + 1;
            m_total   = m_illegal ? 1 : m_len + 1 + m_rel;
            m_rd      = mem_read(m_addr, m_size);
        end
        if (m_active && !m_illegal && m_rw && m_t == m_len + 1) begin
            if (m_is_data) e_d_rdata = m_err ? '0 : m_rd;
            else           e_if_rdata = m_err ? '0 : m_rd;
        end
    endtask

    // Single compare process: check this cycle, then advance the model
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) compare_cycle();
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic access(input bit is_data, input bit rw, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int mov_lat, output bit err_seen);
        lat = -1; mov_lat = -1; err_seen = 0;
        if (is_data) begin
            d_rw = rw; d_size = size; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        for (int n = 1; n <= ACK_BUDGET; n++) begin
            @(posedge clk);
            #1;
            if (mov && mov_lat < 0) mov_lat = n;
            if (is_data ? d_ack : if_ack) begin
                lat = n;
                err_seen = err;
                break;
            end
        end
        if (is_data) d_req = 1'b0;
        else         if_req = 1'b0;
        if (lat < 0) begin
            vectors++;
            errors++;
            $display("FAIL %s_ack_wait: no ack in %0d cycles, required one", is_data ? "d" : "if", ACK_BUDGET);
        end
    endtask

    int          delays [9] = '{0, 0, 1, 2, 3, TIMEOUT - 1, TIMEOUT, TIMEOUT + 1, 1000};
    logic [2:0]  sizes  [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};

    initial begin
        int lat, lat2, ml, ml2;
        bit e, e2, seen;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_rw = 1'b1; d_size = 3'b000; d_addr = '0; d_wdata = '0;
        ram_delay = 0; ram_hold = 0;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0;
        tick(1);
        for (int i = 0; i < 256; i++) begin
            bk_we = 1'b1; bk_addr = 8'(i); bk_data = preload(i);
            tick(1);
        end
        bk_we = 1'b0;
        tick(2);

        // Reset values
        check("rst_mov", 32'(mov), 32'd0);
        check("rst_rw", 32'(read_write), 32'd1);
        check("rst_ms", 32'(ms), 32'd0);
        check("rst_addr", address, 32'd0);
        check("rst_din", data_in, 32'd0);
        check("rst_acks", {29'd0, if_ack, d_ack, err}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Simultaneous requests right after reset: fetch wins the first tie
        fork
            access(1'b0, 1'b1, SIZE_WORD, 32'd5, 32'd0, lat, ml, e);
            access(1'b1, 1'b1, SIZE_BYTE, 32'd14, 32'd0, lat2, ml2, e2);
        join
        check("tie_fetch_lat", 32'(lat), 32'd3);
        check("tie_data_lat", 32'(lat2), 32'd7);
        check("tie_if_rdata", if_rdata, 32'h12345678);
        check("tie_d_rdata", d_rdata, 32'h0000005A);
        tick(2);

        // Single fetch at 18
        access(1'b0, 1'b1, SIZE_WORD, 32'd18, 32'd0, lat, ml, e);
        check("fetch_mov_lat", 32'(ml), 32'd2);
        check("fetch_ack_lat", 32'(lat), 32'd3);
        check("fetch_rdata", if_rdata, 32'hDEADBEEF);
        tick(2);

        // Writes leave d_rdata alone; read-back returns what was written
        access(1'b1, 1'b0, SIZE_BYTE, 32'd0, 32'h000000FF, lat, ml, e);
        check("wr_byte_keep", d_rdata, 32'h0000005A);
        tick(2);
        access(1'b1, 1'b0, SIZE_HALF, 32'd10, 32'h0000FFFF, lat, ml, e);
        check("wr_half_keep", d_rdata, 32'h0000005A);
        tick(2);
        access(1'b1, 1'b0, SIZE_WORD, 32'd13, 32'hC0000001, lat, ml, e);
        check("wr_word_keep", d_rdata, 32'h0000005A);
        tick(2);
        access(1'b1, 1'b1, SIZE_BYTE, 32'd0, 32'd0, lat, ml, e);
        check("rd_byte", d_rdata, 32'h000000FF);
        tick(2);
        access(1'b1, 1'b1, SIZE_HALF, 32'd10, 32'd0, lat, ml, e);
        check("rd_half", d_rdata, 32'h0000FFFF);
        tick(2);
        access(1'b1, 1'b1, SIZE_WORD, 32'd13, 32'd0, lat, ml, e);
        check("rd_word", d_rdata, 32'hC0000001);
        tick(2);

        // MOC never rises: abort after the full timeout
        ram_delay = 1000;
        access(1'b1, 1'b1, SIZE_WORD, 32'd40, 32'd0, lat, ml, e);
        check("to_lat", 32'(lat), 32'(3 + TIMEOUT));
        check("to_err", 32'(e), 32'd1);
        check("to_rdata", d_rdata, 32'd0);
        check("to_mov_low", 32'(mov), 32'd0);
        ram_delay = 0;
        tick(2);

        // Illegal size: no strobe, immediate error ack
        access(1'b1, 1'b1, 3'b011, 32'd20, 32'd0, lat, ml, e);
        check("ill_lat", 32'(lat), 32'd1);
        check("ill_err", 32'(e), 32'd1);
        check("ill_no_mov", 32'(ml < 0), 32'd1);
        tick(2);

        // Reset in the middle of a strobe
        ram_delay = 1000;
        if_addr = 32'd18; if_req = 1'b1;
        tick(4);
        check("mid_mov_before", 32'(mov), 32'd1);
        reset = 1'b1; if_req = 1'b0;
        tick(1);
        check("mid_mov_after", 32'(mov), 32'd0);
        check("mid_no_ack", 32'(if_ack), 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (if_ack) seen = 1;
        end
        check("mid_no_late_ack", 32'(seen), 32'd0);
        ram_delay = 0;
        access(1'b0, 1'b1, SIZE_WORD, 32'd18, 32'd0, lat, ml, e);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_rdata", if_rdata, 32'hDEADBEEF);
        tick(2);

        // Randomized contention under varying RAM behaviour
        for (int ph = 0; ph < 40; ph++) begin
            ram_delay = delays[$urandom_range(0, 8)];
            ram_hold  = $urandom_range(0, 2);
            fork
                begin
                    int fl, fm;
                    bit fe;
                    repeat (3) begin
                        tick($urandom_range(0, 3));
                        access(1'b0, 1'b1, SIZE_WORD, $urandom, 32'd0, fl, fm, fe);
                    end
                end
                begin
                    int dl, dm;
                    bit de;
                    repeat (3) begin
                        tick($urandom_range(0, 3));
                        access(1'b1, 1'($urandom_range(0, 1)), sizes[$urandom_range(0, 4)],
                               $urandom, $urandom, dl, dm, de);
                    end
                end
            join
        end

        tick(8);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
